idu_issue: RTL
==============

Name: idu_issue

Overview:
Decode/issue stage that produces the execute unit's operand and mode inputs: gpr_rdata1, gpr_rdata2, imm and the 4-bit EXU_mode.
- Accepts instructions from the fetch side over valid/ready.
- Decodes the integer subset ADD, SUB, ADDI, SLT, SLTU and LUI, and reads the GPR file.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards.
- Holds one registered output slot toward the EXU with valid/ready.

Parameters:
XLEN, 32, datapath and instruction width
NREG, 32, number of GPRs; scoreboard width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage accepts this cycle
in_inst  in  32  RV32 instruction word
in_pc  in  32  instruction PC
gpr_raddr1  out  5  GPR read address 1 (combinational from in_inst)
gpr_raddr2  out  5  GPR read address 2
gpr_rdata1  in  32  GPR read data 1, combinational
gpr_rdata2  in  32  GPR read data 2, combinational
wb_valid  in  1  writeback completes this cycle
wb_rd  in  5  register being written back
wb_data  in  32  writeback data (used only with the optional bypass)
out_valid  out  1  issue slot holds an instruction
out_ready  in  1  EXU consumes the slot
out_pc  out  32  PC of the issued instruction
out_rdata1  out  32  operand a (feeds gpr_rdata1_in)
out_rdata2  out  32  operand b (feeds gpr_rdata2_in)
out_imm  out  32  sign-extended immediate
out_exu_mode  out  4  EXU_mode code
out_rd  out  5  destination register
out_wen  out  1  writes rd
out_illegal  out  1  instruction not in the decoded subset

Behaviour:
- Reset (async, rst=1): out_valid=0; every out_* register=0; scoreboard cleared. in_ready=0 while rst is high.
- EXU_mode encoding:
  - bit0: imm select.
  - bit1: subtract.
  - bit2: unsigned compare.
  - bit3: signed compare.
- Decode table (mode / imm):
  - ADD (op 0110011, f3 000, f7 0000000): mode 0000.
  - SUB (op 0110011, f3 000, f7 0100000): mode 0010.
  - SLTU (op 0110011, f3 011, f7 0): mode 0100.
  - SLT (op 0110011, f3 010, f7 0): mode 1000.
  - ADDI (op 0010011, f3 000): mode 0001, I-immediate sign-extended.
  - LUI (op 0110111): mode 0001, gpr_raddr1 forced to 0, imm = inst[31:12]<<12.
- Any other encoding is illegal: out_illegal=1, out_wen=0, mode 0000, imm 0, no hazard stall.
- out_wen = legal AND rd != 0.
- Hazard: a source is "used" when rs1 is read by any legal op, or rs2 is read by an R-type op. stall = used AND busy[rs] AND rs != 0.
- in_ready = ~stall AND (~out_valid OR out_ready).
- Accept occurs when in_valid AND in_ready. On the next edge:
  - the output slot loads the decoded fields plus the gpr_rdata values;
  - out_valid=1.
- Latency: 1 cycle from accept to out_valid.
- If out_valid AND out_ready with no accept, out_valid drops to 0 next edge.
- While out_valid=1 and out_ready=0, all out_* registers hold stable.
- Scoreboard:
  - On accept with out_wen, busy[rd] is set.
  - On wb_valid, busy[wb_rd] is cleared.
  - If set and clear target the same index in one cycle, set wins, because the issued instruction is younger.
  - busy[0] is constant 0.
- Without the bypass, a source cleared by wb this cycle still stalls; accept happens the following cycle.
- Throughput: one instruction per cycle with out_ready held high and no hazards.

Optional Feature:
IDU_WB_BYPASS_EN
- Defined: if wb_valid AND wb_rd equals a used, non-zero rs, that source:
  - does not stall;
  - takes wb_data instead of gpr_rdata.
  - A dependent instruction is therefore accepted in the same cycle as its producer's writeback.
- Undefined: wb_data is ignored; stall as specified above.

Decomposition:
- Package idu_pkg:
  - opcode, funct3 and funct7 constants;
  - EXU_mode encodings MODE_ADD=0000, MODE_ADDI=0001, MODE_SUB=0010, MODE_SLTU=0100, MODE_SLT=1000;
  - decoded-instruction struct typedef (rs1, rs2, rd, imm, mode, use_rs1, use_rs2, wen, illegal).
- Sub-module idu_decoder: purely combinational; takes in_inst and returns the struct.
- idu_issue holds the scoreboard, handshake and output register.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), gpr_rdata1=0, out_ready=1 -> next cycle: out_valid=1, out_imm=5, out_exu_mode=0001, out_rd=1, out_wen=1; busy[1]=1.
2. ADD x3,x1,x2 (0x002081B3) presented while busy[1]:
   - in_ready=0 until wb_valid=1, wb_rd=1.
   - Bypass off: accepted the cycle after the writeback.
   - Bypass on with wb_data=5: accepted in the same cycle, out_rdata1=5.
3. Backpressure, out_ready=0 with a slot full -> in_ready=0 and out_* unchanged for 4 cycles. Raise out_ready -> the queued instruction is accepted the same cycle.
4. 0xFFFFFFFF -> out_illegal=1, out_wen=0, out_exu_mode=0000; scoreboard unchanged; no stall even with all busy bits set.
5. SUB x5,x5,x5 (0x405282B3) -> out_exu_mode=0010, busy[5] set. Then ADD x0,x1,x2 (0x00208033) -> out_wen=0, busy[0] remains 0.
6. rst asserted mid-stall with busy bits set -> immediately out_valid=0 and busy=0. After release, a dependent instruction issues without stall.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared decode constants, EXU_mode codes and the decoded-instruction record for the idu_issue slice.
package idu_pkg;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // bit0 imm select, bit1 subtract, bit2 unsigned compare, bit3 signed compare
    typedef enum logic [3:0] {
        MODE_ADD  = 4'b0000,
        MODE_ADDI = 4'b0001,
        MODE_SUB  = 4'b0010,
        MODE_SLTU = 4'b0100,
        MODE_SLT  = 4'b1000
    } exu_mode_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        exu_mode_e   mode;
        logic        use_rs1;
        logic        use_rs2;
        logic        wen;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/idu_decoder.sv
// Combinational decoder for ADD/SUB/SLT/SLTU/ADDI/LUI; anything else comes back flagged illegal.
module idu_decoder
    import idu_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // NOTE: every output gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        dec     = '0;
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.rd  = inst[11:7];
        legal   = 1'b1;

        case (opcode)
            OP_REG: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                if      (funct3 == F3_ADD  && funct7 == F7_ZERO) dec.mode = MODE_ADD;
                else if (funct3 == F3_ADD  && funct7 == F7_SUB)  dec.mode = MODE_SUB;
                else if (funct3 == F3_SLTU && funct7 == F7_ZERO) dec.mode = MODE_SLTU;
                else if (funct3 == F3_SLT  && funct7 == F7_ZERO) dec.mode = MODE_SLT;
                else                                             legal    = 1'b0;
            end
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    dec.use_rs1 = 1'b1;
                    dec.mode    = MODE_ADDI;
                    dec.imm     = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    legal = 1'b0;
                end
            end
            OP_LUI: begin
                // LUI is issued as x0 + imm, so the rs1 port reads the zero register.
                dec.rs1     = 5'd0;
                dec.use_rs1 = 1'b1;
                dec.mode    = MODE_ADDI;
                dec.imm     = {inst[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.use_rs1 = 1'b0;
            dec.use_rs2 = 1'b0;
            dec.mode    = MODE_ADD;
            dec.imm     = '0;
        end
        dec.illegal = !legal;
        dec.wen     = legal && (dec.rd != 5'd0);
    end

endmodule

// File: rtl/idu_issue.sv
// Decode/issue stage: RAW scoreboard, fetch/EXU handshakes and one registered issue slot.
// Optional writeback bypass into the operand path is enabled by defining IDU_WB_BYPASS_EN.
module idu_issue
    import idu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      gpr_raddr1,
    output logic [4:0]      gpr_raddr2,
    input  logic [XLEN-1:0] gpr_rdata1,
    input  logic [XLEN-1:0] gpr_rdata2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_exu_mode,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        exu_mode_e       mode;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } slot_t;

    dec_t            dec;
    slot_t           slot_q, slot_d;
    logic            out_valid_q, out_valid_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            use1, use2, byp1, byp2, stall, accept;

    idu_decoder u_decoder (
        .inst (in_inst),
        .dec  (dec)
    );

    assign gpr_raddr1 = dec.rs1;
    assign gpr_raddr2 = dec.rs2;

`ifdef IDU_WB_BYPASS_EN
    assign byp1 = use1 && wb_valid && (wb_rd == dec.rs1);
    assign byp2 = use2 && wb_valid && (wb_rd == dec.rs2);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        use1     = dec.use_rs1 && (dec.rs1 != 5'd0);
        use2     = dec.use_rs2 && (dec.rs2 != 5'd0);
        stall    = (use1 && busy_q[dec.rs1] && !byp1) || (use2 && busy_q[dec.rs2] && !byp2);
        in_ready = !rst && !stall && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            slot_d.pc      = in_pc;
            slot_d.rdata1  = byp1 ? wb_data : gpr_rdata1;
            slot_d.rdata2  = byp2 ? wb_data : gpr_rdata2;
            slot_d.imm     = dec.imm;
            slot_d.mode    = dec.mode;
            slot_d.rd      = dec.rd;
            slot_d.wen     = dec.wen;
            slot_d.illegal = dec.illegal;
            out_valid_d    = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Set is applied after clear: the newly issued writer is younger than the retiring one.
        busy_d = busy_q;
        if (wb_valid)             busy_d[wb_rd]  = 1'b0;
        if (accept && dec.wen)    busy_d[dec.rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            slot_q      <= '0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            slot_q      <= slot_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = slot_q.pc;
    assign out_rdata1   = slot_q.rdata1;
    assign out_rdata2   = slot_q.rdata2;
    assign out_imm      = slot_q.imm;
    assign out_exu_mode = slot_q.mode;
    assign out_rd       = slot_q.rd;
    assign out_wen      = slot_q.wen;
    assign out_illegal  = slot_q.illegal;

endmodule
